// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared constants and types for the Morse receive path (and future transmit
// checks):
//   - letter index constants L_I..L_P (same encoding as the transmitter's
//     switch select)
//   - per-letter element count / element pattern constants, plus packed tables
//     of them indexed by letter number
//   - ELEM_DOT / ELEM_DASH element encodings
//   - rx_state_e, the receiver FSM state enum
// Patterns hold the first element in bit (count-1) and the last in bit 0.
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MARK    = 3'd1,
        SPACE   = 3'd2,
        DONE    = 3'd3,
        RECOVER = 3'd4
    } rx_state_e;

    localparam logic ELEM_DOT  = 1'b0;
    localparam logic ELEM_DASH = 1'b1;

    localparam logic [2:0] L_I = 3'd0;
    localparam logic [2:0] L_J = 3'd1;
    localparam logic [2:0] L_K = 3'd2;
    localparam logic [2:0] L_L = 3'd3;
    localparam logic [2:0] L_M = 3'd4;
    localparam logic [2:0] L_N = 3'd5;
    localparam logic [2:0] L_O = 3'd6;
    localparam logic [2:0] L_P = 3'd7;

    localparam int NUM_LETTERS = 8;
    localparam int PAT_W       = 4;

    localparam logic [2:0] LEN_I = 3'd2;
    localparam logic [2:0] LEN_J = 3'd4;
    localparam logic [2:0] LEN_K = 3'd3;
    localparam logic [2:0] LEN_L = 3'd4;
    localparam logic [2:0] LEN_M = 3'd2;
    localparam logic [2:0] LEN_N = 3'd2;
    localparam logic [2:0] LEN_O = 3'd3;
    localparam logic [2:0] LEN_P = 3'd4;

    localparam logic [PAT_W-1:0] PAT_I = 4'b0000;
    localparam logic [PAT_W-1:0] PAT_J = 4'b0111;
    localparam logic [PAT_W-1:0] PAT_K = 4'b0101;
    localparam logic [PAT_W-1:0] PAT_L = 4'b0100;
    localparam logic [PAT_W-1:0] PAT_M = 4'b0011;
    localparam logic [PAT_W-1:0] PAT_N = 4'b0010;
    localparam logic [PAT_W-1:0] PAT_O = 4'b0111;
    localparam logic [PAT_W-1:0] PAT_P = 4'b0110;

    // Entry for letter n sits at [n*3 +: 3] / [n*PAT_W +: PAT_W].
    localparam logic [NUM_LETTERS*3-1:0] LETTER_LEN_TBL =
        {LEN_P, LEN_O, LEN_N, LEN_M, LEN_L, LEN_K, LEN_J, LEN_I};
    localparam logic [NUM_LETTERS*PAT_W-1:0] LETTER_PAT_TBL =
        {PAT_P, PAT_O, PAT_N, PAT_M, PAT_L, PAT_K, PAT_J, PAT_I};

endpackage

// File: rtl/morse_lookup.sv
// -----------------------------------------------------------------------------
// morse_lookup
// Combinational decode of a received element sequence to one of letters I..P.
// Ports:
//   elem_count_i   [2:0]            number of elements (1..MAX_ELEMS)
//   elem_bits_i    [MAX_ELEMS-1:0]  1=dash, 0=dot, last element in bit 0
//   letter_idx_o   [2:0]            0=I .. 7=P, 0 when not known
//   letter_known_o                  sequence matches one of I..P
// -----------------------------------------------------------------------------
module morse_lookup
    import morse_pkg::*;
#(
    parameter int MAX_ELEMS = 4
) (
    input  logic [2:0]           elem_count_i,
    input  logic [MAX_ELEMS-1:0] elem_bits_i,
    output logic [2:0]           letter_idx_o,
    output logic                 letter_known_o
);

    localparam int CMP_W = (MAX_ELEMS > PAT_W) ? MAX_ELEMS : PAT_W;

    logic [CMP_W-1:0]       bits_ext;
    logic [NUM_LETTERS-1:0] match;

    assign bits_ext = CMP_W'(elem_bits_i);

    // Count and pattern must both match: J and O share a pattern value but
    // differ in length.
    generate
        for (genvar gi = 0; gi < NUM_LETTERS; gi++) begin : g_match
            assign match[gi] = (elem_count_i == LETTER_LEN_TBL[gi*3 +: 3]) &&
                               (bits_ext == CMP_W'(LETTER_PAT_TBL[gi*PAT_W +: PAT_W]));
        end
    endgenerate

    // Matches are mutually exclusive, so a simple scan is enough.
    always_comb begin
        letter_idx_o   = 3'd0;
        letter_known_o = 1'b0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (match[i]) begin
                letter_idx_o   = 3'(i);
                letter_known_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// -----------------------------------------------------------------------------
// morse_rx_decoder
// Receives a Morse on/off stream sampled once per symbol-unit tick, measures
// mark/space run lengths, rebuilds the dot/dash sequence of one letter and
// reports which of letters I..P it is.
// Ports:
//   clock          system clock
//   reset          asynchronous, active-low reset
//   tick           one-cycle sample strobe per symbol unit
//   serial_in      Morse line, 1 = mark, 0 = space
//   letter_valid   one-cycle pulse, letter outputs updated
//   letter_idx     0=I .. 7=P (0 when letter_known=0)
//   letter_known   received sequence is one of I..P
//   elem_bits      1=dash/0=dot, first element in bit elem_count-1
//   elem_count     number of elements in the letter
//   frame_err      one-cycle pulse on a framing violation
// Build option: define MORSE_RX_SYNC_EN to pass serial_in through a 2-flop
// synchronizer before sampling (ticks must then trail a line change by at
// least 2 clocks).
// -----------------------------------------------------------------------------
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int MAX_ELEMS  = 4,
    parameter int DASH_UNITS = 3,
    parameter int GAP_UNITS  = 3,
    parameter int CNT_W      = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 serial_in,
    output logic                 letter_valid,
    output logic [2:0]           letter_idx,
    output logic                 letter_known,
    output logic [MAX_ELEMS-1:0] elem_bits,
    output logic [2:0]           elem_count,
    output logic                 frame_err
);

    logic line_s;

`ifdef MORSE_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], serial_in};
        end
    end

    assign line_s = sync_q[1];
`else
    assign line_s = serial_in;
`endif

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     run_q, run_d;
    logic [MAX_ELEMS-1:0] shreg_q, shreg_d;
    logic [2:0]           count_q, count_d;
    logic                 valid_d, err_d;

    logic                 letter_valid_q, frame_err_q, letter_known_q;
    logic [2:0]           letter_idx_q, elem_count_q;
    logic [MAX_ELEMS-1:0] elem_bits_q;

    logic [2:0]           look_idx;
    logic                 look_known;

    logic [CNT_W-1:0]     run_inc;
    logic                 is_dot, is_dash;

    assign run_inc = run_q + CNT_W'(1);
    assign is_dot  = (run_q == CNT_W'(1));
    assign is_dash = (run_q == CNT_W'(DASH_UNITS));

    morse_lookup #(
        .MAX_ELEMS (MAX_ELEMS)
    ) u_lookup (
        .elem_count_i   (count_q),
        .elem_bits_i    (shreg_q),
        .letter_idx_o   (look_idx),
        .letter_known_o (look_known)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_q   <= '0;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

    // Next-state logic. Only tick cycles change the letter state; DONE is the
    // single exception, a one-clock state that publishes the letter.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        shreg_d = shreg_q;
        count_d = count_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // Spaces here (including transmitter padding) are ignored.
                if (tick && line_s) begin
                    state_d = MARK;
                    run_d   = CNT_W'(1);
                end
            end

            MARK: begin
                if (tick) begin
                    if (line_s) begin
                        if (run_q >= CNT_W'(DASH_UNITS)) begin
                            err_d   = 1'b1;
                            state_d = RECOVER;
                            run_d   = '0;
                            shreg_d = '0;
                            count_d = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (!(is_dot || is_dash) ||
                                 (count_q == 3'(MAX_ELEMS))) begin
                        // Bad mark length or too many elements. The space
                        // that exposed it counts toward the recovery gap.
                        err_d   = 1'b1;
                        state_d = RECOVER;
                        run_d   = CNT_W'(1);
                        shreg_d = '0;
                        count_d = '0;
                    end else begin
                        shreg_d = (shreg_q << 1) |
                                  MAX_ELEMS'(is_dash ? ELEM_DASH : ELEM_DOT);
                        count_d = count_q + 3'd1;
                        state_d = SPACE;
                        run_d   = CNT_W'(1);
                    end
                end
            end

            SPACE: begin
                if (tick) begin
                    if (!line_s) begin
                        if (run_inc >= CNT_W'(GAP_UNITS)) begin
                            state_d = DONE;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (run_q == CNT_W'(1)) begin
                        state_d = MARK;
                        run_d   = CNT_W'(1);
                    end else begin
                        // Gap longer than an intra-letter space but shorter
                        // than a letter gap.
                        err_d   = 1'b1;
                        state_d = RECOVER;
                        run_d   = '0;
                        shreg_d = '0;
                        count_d = '0;
                    end
                end
            end

            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
                run_d   = '0;
                shreg_d = '0;
                count_d = '0;
            end

            RECOVER: begin
                if (tick) begin
                    if (line_s) begin
                        run_d = '0;
                    end else if (run_inc >= CNT_W'(GAP_UNITS)) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                run_d   = '0;
                shreg_d = '0;
                count_d = '0;
            end
        endcase
    end

    // Output registers: pulses for one clock, letter fields hold until the
    // next letter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            letter_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            letter_idx_q   <= 3'd0;
            letter_known_q <= 1'b0;
            elem_bits_q    <= '0;
            elem_count_q   <= 3'd0;
        end else begin
            letter_valid_q <= valid_d;
            frame_err_q    <= err_d;
            if (valid_d) begin
                letter_idx_q   <= look_idx;
                letter_known_q <= look_known;
                elem_bits_q    <= shreg_q;
                elem_count_q   <= count_q;
            end
        end
    end

    assign letter_valid = letter_valid_q;
    assign frame_err    = frame_err_q;
    assign letter_idx   = letter_idx_q;
    assign letter_known = letter_known_q;
    assign elem_bits    = elem_bits_q;
    assign elem_count   = elem_count_q;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_rx_decoder
// Self-checking bench for morse_rx_decoder. Streams are built letter by letter
// from the Morse timing rules; each tick carries its expected frame_err and
// letter_valid result, and letter fields come from a reference letter table.
// -----------------------------------------------------------------------------
module tb_morse_rx_decoder;

    localparam int MAX_ELEMS = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 tick = 1'b0;
    logic                 serial_in = 1'b0;
    logic                 letter_valid;
    logic [2:0]           letter_idx;
    logic                 letter_known;
    logic [MAX_ELEMS-1:0] elem_bits;
    logic [2:0]           elem_count;
    logic                 frame_err;

    morse_rx_decoder #(
        .MAX_ELEMS  (MAX_ELEMS),
        .DASH_UNITS (3),
        .GAP_UNITS  (3),
        .CNT_W      (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .serial_in    (serial_in),
        .letter_valid (letter_valid),
        .letter_idx   (letter_idx),
        .letter_known (letter_known),
        .elem_bits    (elem_bits),
        .elem_count   (elem_count),
        .frame_err    (frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit         b;
        bit         err;
        bit         val;
        logic [2:0] idx;
        bit         known;
        logic [3:0] bits;
        logic [2:0] cnt;
    } tick_t;

    tick_t q[$];
    int    checks = 0;
    int    errors = 0;

    // Reference letters I..P: element count and dash pattern (first element
    // in the highest used bit).
    int         ref_len [8] = '{2, 4, 3, 4, 2, 2, 3, 4};
    logic [3:0] ref_pat [8] = '{4'b0000, 4'b0111, 4'b0101, 4'b0100,
                                4'b0011, 4'b0010, 4'b0111, 4'b0110};

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic void ref_lookup(input int cnt, input logic [3:0] bits,
                                       output logic [2:0] idx, output bit known);
        idx   = 3'd0;
        known = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (cnt == ref_len[i] && bits == ref_pat[i]) begin
                idx   = 3'(i);
                known = 1'b1;
            end
        end
    endfunction

    function automatic void push(input bit b, input bit err = 1'b0,
                                 input bit val = 1'b0, input int cnt = 0,
                                 input logic [3:0] bits = 4'd0);
        tick_t t;
        t.b    = b;
        t.err  = err;
        t.val  = val;
        t.cnt  = 3'(cnt);
        t.bits = bits;
        t.idx  = 3'd0;
        t.known = 1'b0;
        if (val) ref_lookup(cnt, bits, t.idx, t.known);
        q.push_back(t);
    endfunction

    function automatic void push_marks(input bit dash);
        repeat (dash ? 3 : 1) push(1'b1);
    endfunction

    // A well-formed letter: n elements, one-unit gaps, three-unit letter gap,
    // then 'extra' further spaces.
    function automatic void add_letter(input int n, input logic [3:0] pat,
                                       input int extra);
        for (int e = n - 1; e >= 0; e--) begin
            push_marks(pat[e]);
            if (e > 0) push(1'b0);
        end
        push(1'b0);
        push(1'b0);
        push(1'b0, 1'b0, 1'b1, n, pat);
        repeat (extra) push(1'b0);
    endfunction

    // Erroneous letters; each ends with four spaces so the receiver is idle.
    function automatic void add_err(input int kind);
        int pre;
        pre = $urandom_range(0, 2);
        case (kind)
            0: begin // two-unit mark
                repeat (pre) begin push_marks(1'($urandom)); push(1'b0); end
                push(1'b1); push(1'b1); push(1'b0, 1'b1);
            end
            1: begin // mark of four or five units
                repeat (pre) begin push_marks(1'($urandom)); push(1'b0); end
                push(1'b1); push(1'b1); push(1'b1); push(1'b1, 1'b1);
                if ($urandom_range(0, 1) == 1) push(1'b1);
            end
            2: begin // two-unit gap inside a letter
                repeat (pre + 1) begin push_marks(1'($urandom)); push(1'b0); end
                push(1'b0); push(1'b1, 1'b1);
            end
            default: begin // five elements
                repeat (4) begin push_marks(1'($urandom)); push(1'b0); end
                push_marks(1'($urandom));
                push(1'b0, 1'b1);
            end
        endcase
        repeat (4) push(1'b0);
    endfunction

    task automatic send_tick(input tick_t t);
        serial_in = t.b;
        repeat ($urandom_range(2, 4)) @(posedge clock);
        #1 tick = 1'b1;
        @(posedge clock);
        #1 tick = 1'b0;
        check_val("frame_err", 32'(frame_err), 32'(t.err));
        check_val("valid_early", 32'(letter_valid), 32'd0);
        @(posedge clock);
        #1;
        check_val("letter_valid", 32'(letter_valid), 32'(t.val));
        check_val("frame_err_width", 32'(frame_err), 32'd0);
        if (t.val) begin
            check_val("letter_idx", 32'(letter_idx), 32'(t.idx));
            check_val("letter_known", 32'(letter_known), 32'(t.known));
            check_val("elem_count", 32'(elem_count), 32'(t.cnt));
            check_val("elem_bits", 32'(elem_bits), 32'(t.bits));
            $display("letter cnt=%0d bits=%b idx=%0d known=%0d",
                     t.cnt, t.bits, letter_idx, letter_known);
        end
        if (t.err) $display("frame error flagged");
    endtask

    task automatic run_queue();
        tick_t t;
        while (q.size() > 0) begin
            t = q.pop_front();
            send_tick(t);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(letter_valid), 32'd0);
        check_val({tag, "_idx"}, 32'(letter_idx), 32'd0);
        check_val({tag, "_known"}, 32'(letter_known), 32'd0);
        check_val({tag, "_bits"}, 32'(elem_bits), 32'd0);
        check_val({tag, "_count"}, 32'(elem_count), 32'd0);
        check_val({tag, "_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clock);
        #1;

        add_letter(2, 4'b0000, 2);        // I
        add_letter(4, 4'b0111, 0);        // J
        add_letter(2, 4'b0011, 0);        // M
        add_letter(4, 4'b0110, 2);        // P, back to back
        push(1'b1); push(1'b1); push(1'b0, 1'b1);
        repeat (4) push(1'b0);            // two-unit mark
        add_letter(2, 4'b0010, 0);        // N
        repeat (4) begin push(1'b1); push(1'b0); end
        push(1'b1); push(1'b0, 1'b1);     // fifth dot overflows
        repeat (4) push(1'b0);
        push(1'b1); push(1'b1); push(1'b1); push(1'b0); push(1'b1);
        run_queue();

        // Reset in the middle of K.
        reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clock);
        #1 reset = 1'b1;
        add_letter(3, 4'b0101, 1);        // K
        run_queue();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                int n;
                n = $urandom_range(1, 4);
                add_letter(n, 4'($urandom & ((1 << n) - 1)), $urandom_range(0, 2));
            end else begin
                add_err($urandom_range(0, 3));
            end
            run_queue();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_rx_decoder.md
Name: morse_rx_decoder

Overview:
Downstream stage of the Morse letter transmitter. Samples its serial on/off stream once per symbol-unit tick and measures mark and space run lengths. Reassembles the dot/dash sequence of one letter and reports which of letters I..P it is (index 0..7), with the same index encoding as the transmitter's switch select. Intended for loopback on the board (transmitter LEDR[0] -> this block) and for self-checking benches.

Parameters:
- MAX_ELEMS, 4: maximum dots/dashes per letter; a letter with more elements is a framing error.
- DASH_UNITS, 3: mark length in ticks that counts as a dash. A mark of 1 tick is a dot.
- GAP_UNITS, 3: consecutive space ticks that terminate a letter.
- CNT_W, 3: run-length counter width; must hold max(DASH_UNITS, GAP_UNITS)+1.

Ports:
- clock, in, 1: system clock (CLOCK_50).
- reset, in, 1: reset, asynchronous, active-low.
- tick, in, 1: one-cycle sample strobe per symbol unit, phase-aligned near mid-unit by integration.
- serial_in, in, 1: Morse line; 1 = mark, 0 = space.
- letter_valid, out, 1: one-cycle pulse; the outputs below are valid.
- letter_idx, out, 3: 0=I 1=J 2=K 3=L 4=M 5=N 6=O 7=P; 0 when letter_known=0.
- letter_known, out, 1: received sequence matches one of I..P.
- elem_bits, out, MAX_ELEMS: 1=dash, 0=dot. First element is in bit elem_count-1; the last element is in bit 0. Upper bits are 0.
- elem_count, out, 3: number of elements, 1..MAX_ELEMS.
- frame_err, out, 1: one-cycle pulse on any framing violation.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; run counter, element shift register and element count all cleared. Reset mid-letter discards the partial letter and emits no pulse.
- serial_in is sampled only in cycles with tick=1. All state changes occur on those cycles, except the output pulses, which last exactly one clock.
- FSM states:
  - IDLE: space ticks are ignored. A mark tick -> MARK with run=1.
  - MARK: a mark tick increments run. If run would exceed DASH_UNITS -> frame_err, go to RECOVER. A space tick classifies the run (1 = dot, DASH_UNITS = dash, anything else = frame_err -> RECOVER), shifts the element into elem_bits at the LSB, increments the count, and goes to SPACE with run=1.
  - SPACE: a space tick increments run. When run reaches GAP_UNITS -> DONE. A mark tick with run==1 -> MARK with run=1. A mark tick with 1<run<GAP_UNITS -> frame_err -> RECOVER.
  - DONE: a single clock state (no tick needed). Assert letter_valid, drive the outputs, clear the letter state, then go to IDLE.
  - RECOVER: wait for GAP_UNITS consecutive space ticks. A mark tick restarts the count. Then go to IDLE. No letter_valid is emitted for the errored letter.
- Overflow: classifying an element when count==MAX_ELEMS -> frame_err -> RECOVER.
- Latency: letter_valid asserts on the clock edge after the tick that samples the GAP_UNITS-th space.
- Trailing zeros from the transmitter's 16-bit shift pattern are absorbed in IDLE.
- The output registers letter_idx, letter_known, elem_bits and elem_count hold their last values between pulses. frame_err never coincides with letter_valid.
- Lookup (count:bits):
  - I = 2:00
  - J = 4:0111
  - K = 3:101
  - L = 4:0100
  - M = 2:11
  - N = 2:10
  - O = 3:111
  - P = 4:0110
  - Anything else gives letter_known=0.

Optional Feature:
- MORSE_RX_SYNC_EN defined: serial_in passes through a 2-flop synchronizer clocked by clock and reset by reset (async to 0). The sampled value is the synchronizer output; tick placement must allow the 2-cycle delay.
- Not defined: serial_in is sampled directly (same-clock-domain source).

Decomposition:
- Package morse_pkg holds:
  - the letter index constants L_I..L_P;
  - the per-letter element count and element pattern constants;
  - the ELEM_DOT/ELEM_DASH encodings;
  - the FSM state enum (IDLE, MARK, SPACE, DONE, RECOVER).
- One sub-module, morse_lookup: combinational (elem_count, elem_bits) -> (letter_idx, letter_known), shared with future transmitter checks.

Test Plan:
- Ticks every 4 clocks, stream 10100000 (I) -> one letter_valid, letter_idx=0, known=1, elem_count=2, elem_bits=0000.
- Stream 1011101110111000 (J) -> idx=1, count=4, bits=0111, valid 1 clock after the 3rd trailing space tick.
- Stream 1110111 then 000 (M) -> idx=4, bits=0011. Then 1011101110100000 (P) back-to-back -> second pulse idx=7, bits=0110.
- Mark of 2 ticks (110000) -> frame_err pulse on the first space tick, no letter_valid. Next clean 11101000 -> idx=5 (N).
- Stream 10101010100 (5 dots) -> frame_err on the 5th classification, no letter_valid.
- Assert reset low mid-K (after 11101) -> outputs 0 immediately. After release, full K -> idx=2, bits=101, no stale elements.
